axi_stream_fifo: RTL and testbench

Parametrised synchronous FIFO between two AXI-stream style ports: valid/ready on the output, and on the input either full valid/ready back-pressure or a no-ready producer mode. It buffers producer data ahead of consumers that cannot accept every cycle, such as systolic-array feeders and DMA write paths. It also reports occupancy, an almost-full flag and a saturating count of words dropped in no-ready mode.

---
 rtl/axi_stream_fifo.sv | 92 +++++++++
 tb/tb_axi_stream_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_fifo.sv
// axi_stream_fifo: first-word fall-through FIFO between valid/ready stream ports,
// with occupancy, almost-full and an optional drop mode for producers that ignore ready.
module axi_stream_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int AF_THRESH   = DEPTH - 2,
  parameter int NO_READY_IN = 0,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    s_axi_data,
  input  logic                     s_axi_valid,
  output logic                     s_axi_ready,
  output logic [DATA_WIDTH-1:0]    m_axi_data,
  output logic                     m_axi_valid,
  input  logic                     m_axi_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Flush wins over everything; a full FIFO never accepts, even when popping.
  always_comb begin
    full = (count == FULL_CNT);
    push = s_axi_valid && !full && !flush;
    pop  = (count != '0) && m_axi_ready && !flush;
    drop = (NO_READY_IN != 0) && s_axi_valid && full && !flush;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_axi_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating drop counter, only ever advanced in no-ready mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (flush) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  assign s_axi_ready = !full;
  assign m_axi_valid = (count != '0);
  assign m_axi_data  = mem[rd_ptr];
  assign level       = count;
  assign almost_full = (count >= AF_CNT);

endmodule

// File: tb/tb_axi_stream_fifo.sv
// tb_axi_stream_fifo: directed vectors and corner-case sequences for axi_stream_fifo
// in back-pressure mode, drop mode and drop mode with a 2-bit saturating counter.
module tb_axi_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          bp_flush = 1'b0, bp_valid = 1'b0, bp_mready = 1'b0;
  logic [DW-1:0] bp_data = '0;
  logic          bp_sready, bp_mvalid, bp_af;
  logic [DW-1:0] bp_mdata;
  logic [4:0]    bp_level;
  logic [15:0]   bp_drop;

  logic          dr_flush = 1'b0, dr_valid = 1'b0, dr_mready = 1'b0;
  logic [DW-1:0] dr_data = '0;
  logic          dr_sready, dr_mvalid, dr_af;
  logic [DW-1:0] dr_mdata;
  logic [4:0]    dr_level;
  logic [15:0]   dr_drop;

  logic          sat_sready, sat_mvalid, sat_af;
  logic [DW-1:0] sat_mdata;
  logic [4:0]    sat_level;
  logic [1:0]    sat_drop;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] bq[$];

  always #5 clk = ~clk;

  axi_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NO_READY_IN(0)) dut_bp (
    .clk(clk), .rst(rst), .flush(bp_flush),
    .s_axi_data(bp_data), .s_axi_valid(bp_valid), .s_axi_ready(bp_sready),
    .m_axi_data(bp_mdata), .m_axi_valid(bp_mvalid), .m_axi_ready(bp_mready),
    .level(bp_level), .almost_full(bp_af), .drop_count(bp_drop)
  );

  axi_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NO_READY_IN(1)) dut_dr (
    .clk(clk), .rst(rst), .flush(dr_flush),
    .s_axi_data(dr_data), .s_axi_valid(dr_valid), .s_axi_ready(dr_sready),
    .m_axi_data(dr_mdata), .m_axi_valid(dr_mvalid), .m_axi_ready(dr_mready),
    .level(dr_level), .almost_full(dr_af), .drop_count(dr_drop)
  );

  axi_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NO_READY_IN(1), .DROP_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(dr_flush),
    .s_axi_data(dr_data), .s_axi_valid(dr_valid), .s_axi_ready(sat_sready),
    .m_axi_data(sat_mdata), .m_axi_valid(sat_mvalid), .m_axi_ready(dr_mready),
    .level(sat_level), .almost_full(sat_af), .drop_count(sat_drop)
  );

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          mready;
    logic [4:0]    exp_level;
    logic          exp_mvalid;
    logic          chk_data;
    logic [DW-1:0] exp_mdata;
    logic          exp_sready;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle on the back-pressure instance, checked against a reference queue.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic mr, input logic fl);
    logic          acc;
    logic          popd;
    logic [DW-1:0] tmp;
    bp_valid  = v;
    bp_data   = d;
    bp_mready = mr;
    bp_flush  = fl;
    acc  = v && !fl && (bq.size() < DEPTH);
    popd = mr && !fl && (bq.size() > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      bq.delete();
    end else begin
      if (popd) tmp = bq.pop_front();
      if (acc) bq.push_back(d);
    end
    checkOutput("bp_level", bp_level, bq.size());
    checkOutput("bp_mvalid", bp_mvalid, bq.size() != 0);
    checkOutput("bp_sready", bp_sready, bq.size() < DEPTH);
    checkOutput("bp_af", bp_af, bq.size() >= DEPTH - 2);
    checkOutput("bp_drop", bp_drop, 0);
    if (bq.size() > 0) checkOutput("bp_mdata", bp_mdata, bq[0]);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   w;
    int   guard;
    int   exp_lvl;
    int   exp_drop;
    int   exp_sat;

    vecs[0] = '{1'b1, 32'h11, 1'b0, 5'd1, 1'b1, 1'b1, 32'h11, 1'b1};
    vecs[1] = '{1'b1, 32'h22, 1'b0, 5'd2, 1'b1, 1'b1, 32'h11, 1'b1};
    vecs[2] = '{1'b1, 32'h33, 1'b0, 5'd3, 1'b1, 1'b1, 32'h11, 1'b1};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 5'd2, 1'b1, 1'b1, 32'h22, 1'b1};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 5'd1, 1'b1, 1'b1, 32'h33, 1'b1};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 5'd0, 1'b0, 1'b0, 32'h00, 1'b1};

    #12;
    checkOutput("rst_mvalid", bp_mvalid, 0);
    checkOutput("rst_level", bp_level, 0);
    checkOutput("rst_sready", bp_sready, 1);
    checkOutput("rst_af", bp_af, 0);
    checkOutput("rst_drop", dr_drop, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic order");
    for (int i = 0; i < 6; i++) begin
      bp_valid  = vecs[i].valid;
      bp_data   = vecs[i].data;
      bp_mready = vecs[i].mready;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_level", i), bp_level, vecs[i].exp_level);
      checkOutput($sformatf("vec%0d_mvalid", i), bp_mvalid, vecs[i].exp_mvalid);
      checkOutput($sformatf("vec%0d_sready", i), bp_sready, vecs[i].exp_sready);
      if (vecs[i].chk_data) checkOutput($sformatf("vec%0d_mdata", i), bp_mdata, vecs[i].exp_mdata);
    end

    $display("[TB] fill and back-pressure");
    w = 0;
    for (int k = 0; k < 20; k++) begin
      logic acc;
      acc = (bq.size() < DEPTH);
      applyStimulus(1'b1, DW'(w), 1'b0, 1'b0);
      if (acc) w++;
    end
    checkOutput("fill_level", bp_level, 16);
    checkOutput("fill_sready", bp_sready, 0);
    checkOutput("fill_af", bp_af, 1);
    checkOutput("fill_accepted", w, 16);

    applyStimulus(1'b1, DW'(w), 1'b1, 1'b0);
    checkOutput("full_pop_level", bp_level, 15);
    checkOutput("full_pop_sready", bp_sready, 1);
    checkOutput("full_pop_mdata", bp_mdata, 1);

    guard = 0;
    while ((bq.size() > 0 || w < 20) && guard < 100) begin
      logic acc;
      acc = (w < 20) && (bq.size() < DEPTH);
      applyStimulus(w < 20, DW'(w), 1'b1, 1'b0);
      if (acc) w++;
      guard++;
    end
    if (guard >= 100) checkOutput("drain_timeout", 1, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] push and pop at level 1");
    applyStimulus(1'b1, 32'd100, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, DW'(101 + k), 1'b1, 1'b0);
      checkOutput("lvl1_level", bp_level, 1);
      checkOutput("lvl1_mdata", bp_mdata, 101 + k);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] flush");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, DW'(200 + k), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1);
    checkOutput("flush_level", bp_level, 0);
    checkOutput("flush_mvalid", bp_mvalid, 0);
    checkOutput("flush_drop", bp_drop, 0);
    applyStimulus(1'b1, 32'd300, 1'b0, 1'b0);
    checkOutput("post_flush_mdata", bp_mdata, 300);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset");
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, DW'(400 + k), 1'b0, 1'b0);
    checkOutput("pre_rst_level", bp_level, 8);
    bp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_mvalid", bp_mvalid, 0);
    checkOutput("async_rst_level", bp_level, 0);
    checkOutput("async_rst_sready", bp_sready, 1);
    #1;
    rst = 1'b0;
    bq.delete();

    $display("[TB] drop mode");
    for (int k = 0; k < 22; k++) begin
      dr_valid  = 1'b1;
      dr_data   = DW'(k);
      dr_mready = 1'b0;
      @(posedge clk);
      #1;
      exp_lvl  = (k + 1 < DEPTH) ? k + 1 : DEPTH;
      exp_drop = (k + 1 > DEPTH) ? k + 1 - DEPTH : 0;
      exp_sat  = (exp_drop > 3) ? 3 : exp_drop;
      checkOutput("dr_level", dr_level, exp_lvl);
      checkOutput("dr_sready", dr_sready, exp_lvl < DEPTH);
      checkOutput("dr_drop", dr_drop, exp_drop);
      checkOutput("sat_level", sat_level, exp_lvl);
      checkOutput("sat_drop", sat_drop, exp_sat);
      if (k == 19) checkOutput("dr_drop_at_20", dr_drop, 4);
    end
    dr_valid  = 1'b0;
    dr_mready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      checkOutput("dr_mdata", dr_mdata, j);
      checkOutput("sat_mdata", sat_mdata, j);
      @(posedge clk);
      #1;
      checkOutput("dr_drain_level", dr_level, 15 - j);
    end
    checkOutput("dr_empty_mvalid", dr_mvalid, 0);
    checkOutput("dr_drop_kept", dr_drop, 6);
    checkOutput("sat_drop_kept", sat_drop, 3);

    dr_mready = 1'b0;
    dr_valid  = 1'b1;
    dr_data   = 32'hBEEF;
    dr_flush  = 1'b1;
    @(posedge clk);
    #1;
    dr_flush = 1'b0;
    dr_valid = 1'b0;
    checkOutput("dr_flush_drop", dr_drop, 0);
    checkOutput("sat_flush_drop", sat_drop, 0);
    checkOutput("dr_flush_level", dr_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
